// File: rtl/mezclador_audio_pkg.sv
// Shared constants, FSM states and saturation helper for the audio mixer.
package audio_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int ACC_W     = 19;
    localparam int TERM_W    = 16;
    localparam int NUM_TERMS = 6;
    localparam int SAT_MAX   = 32767;
    localparam int SAT_MIN   = -32768;

    localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(SAT_MIN);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT,
        OUT
    } state_t;

    localparam logic [2:0] CH_AY_A   = 3'd0;
    localparam logic [2:0] CH_AY_B   = 3'd1;
    localparam logic [2:0] CH_AY_C   = 3'd2;
    localparam logic [2:0] CH_COVOX  = 3'd3;
    localparam logic [2:0] CH_BEEPER = 3'd4;
    localparam logic [2:0] CH_EAR    = 3'd5;

    function automatic logic signed [SAMPLE_W-1:0] saturar(input logic signed [ACC_W-1:0] a);
        if (a > ACC_HI) begin
            return SAMPLE_W'(SAT_MAX);
        end else if (a < ACC_LO) begin
            return SAMPLE_W'(SAT_MIN);
        end
        return a[SAMPLE_W-1:0];
    endfunction
endpackage

// File: rtl/mezclador_audio_escalado_canal.sv
// Combinational channel scaler: recentres an unsigned 8-bit source and applies a 4-bit volume.
module escalado_canal
    import audio_pkg::*;
(
    input  logic [7:0]               x,
    input  logic [3:0]               v,
    output logic signed [TERM_W-1:0] term
);
    logic signed [8:0]  centred;
    logic signed [13:0] prod;

    always_comb begin
        centred = $signed({1'b0, x}) - 9'sd128;
        prod    = centred * $signed({1'b0, v});
        term    = TERM_W'(prod) <<< 3;
    end
endmodule

// File: rtl/mezclador_audio.sv
// Time-multiplexed mixer: snapshots all sources on the sample strobe, accumulates
// one term per cycle, saturates and emits a single signed sample with a one-cycle strobe.
module mezclador_audio
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 875,
    parameter int BEEP_LEVEL = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ay_a,
    input  logic [7:0]  ay_b,
    input  logic [7:0]  ay_c,
    input  logic [7:0]  covox,
    input  logic        beeper,
    input  logic        ear,
    input  logic [15:0] vol,
    input  logic        mute,
    output logic [15:0] sample,
    output logic        sample_en
);
    if (CLK_DIV < 10) begin : g_bad_clk_div
        $error("mezclador_audio: CLK_DIV must be >= 10");
    end

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic signed [ACC_W-1:0] BEEP_TERM = ACC_W'(BEEP_LEVEL);
    localparam logic signed [ACC_W-1:0] EAR_TERM  = ACC_W'(BEEP_LEVEL / 4);

    logic [DIV_W-1:0]           div_q, div_d;
    logic                       start;
    state_t                     state_q, state_d;
    logic [2:0]                 idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [3:0][7:0]            pcm_in, pcm_q, pcm_d;
    logic [15:0]                vol_q, vol_d;
    logic                       beeper_q, beeper_d;
    logic                       ear_q, ear_d;
    logic                       mute_q, mute_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       sample_en_q, sample_en_d;
    logic signed [TERM_W-1:0]   scaled;
    logic signed [ACC_W-1:0]    term_sel;

    assign pcm_in = {covox, ay_c, ay_b, ay_a};
    assign start  = (div_q == DIV_LAST);

    // Snapshot registers only move on the strobe so later input changes cannot leak in.
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
        assign pcm_d[gi] = start ? pcm_in[gi] : pcm_q[gi];
    end

    escalado_canal u_escalado (
        .x    (pcm_q[idx_q[1:0]]),
        .v    (vol_q[{idx_q[1:0], 2'b00} +: 4]),
        .term (scaled)
    );

    always_comb begin
        case (idx_q)
            CH_BEEPER: term_sel = beeper_q ? BEEP_TERM : -BEEP_TERM;
            CH_EAR:    term_sel = ear_q ? EAR_TERM : -EAR_TERM;
            default:   term_sel = ACC_W'(scaled);
        endcase
    end

    always_comb begin
        div_d       = start ? '0 : div_q + 1'b1;
        vol_d       = start ? vol : vol_q;
        beeper_d    = start ? beeper : beeper_q;
        ear_d       = start ? ear : ear_q;
        mute_d      = start ? mute : mute_q;
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        sample_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    idx_d   = CH_AY_A;
                    acc_d   = '0;
                end
            end
            ACC: begin
                acc_d = acc_q + term_sel;
                if (idx_q == 3'(NUM_TERMS - 1)) begin
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SAT: begin
                state_d     = OUT;
                sample_en_d = 1'b1;
                sample_d    = mute_q ? '0 : saturar(acc_q);
            end
            OUT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            pcm_q       <= '0;
            vol_q       <= '0;
            beeper_q    <= 1'b0;
            ear_q       <= 1'b0;
            mute_q      <= 1'b0;
            sample_q    <= '0;
            sample_en_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            pcm_q       <= pcm_d;
            vol_q       <= vol_d;
            beeper_q    <= beeper_d;
            ear_q       <= ear_d;
            mute_q      <= mute_d;
            sample_q    <= sample_d;
            sample_en_q <= sample_en_d;
        end
    end

    assign sample    = sample_q;
    assign sample_en = sample_en_q;
endmodule

// File: tb/tb_mezclador_audio.sv
// Directed bench for mezclador_audio with a queue of expected samples checked on each strobe.
module tb_mezclador_audio;
    localparam int CLK_DIV = 875;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ay_a = 8'd128, ay_b = 8'd128, ay_c = 8'd128, covox = 8'd128;
    logic        beeper = 1'b0, ear = 1'b0, mute = 1'b0;
    logic [15:0] vol = 16'hFFFF;
    logic [15:0] sample;
    logic        sample_en;

    int cyc = 0;
    int next_cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mezclador_audio #(.CLK_DIV(CLK_DIV), .BEEP_LEVEL(8192)) dut (
        .clk       (clk),
        .rst       (rst),
        .ay_a      (ay_a),
        .ay_b      (ay_b),
        .ay_c      (ay_c),
        .covox     (covox),
        .beeper    (beeper),
        .ear       (ear),
        .vol       (vol),
        .mute      (mute),
        .sample    (sample),
        .sample_en (sample_en)
    );

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] cv,
                                          input logic [15:0] vl, input logic bp,
                                          input logic er, input logic mu);
        int s;
        int xs[4];
        xs[0] = int'(a); xs[1] = int'(b); xs[2] = int'(c); xs[3] = int'(cv);
        s = 0;
        for (int i = 0; i < 4; i++) s += (xs[i] - 128) * int'((vl >> (4 * i)) & 16'hF) * 8;
        s += bp ? 8192 : -8192;
        s += er ? 2048 : -2048;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (mu) s = 0;
        return s[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_expected();
        exp_q.push_back(model(ay_a, ay_b, ay_c, covox, vol, beeper, ear, mute));
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(input string tag);
        logic [15:0] held;
        logic [15:0] want;
        logic [15:0] got;
        logic        changed;
        int          n;
        held    = sample;
        changed = 1'b0;
        n       = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!sample_en && sample !== held) changed = 1'b1;
        end while (!sample_en && n < 2000);
        check({tag, " strobe"}, 32'(sample_en), 32'd1);
        check({tag, " strobe_cycle"}, cyc, next_cyc);
        check({tag, " held"}, 32'(changed), 32'd0);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        got  = sample;
        $display("strobe %s at cycle %0d: sample=%0h expected=%0h", tag, cyc, sample, want);
        check({tag, " sample"}, 32'(sample), 32'(want));
        @(posedge clk);
        #1;
        check({tag, " one_wide"}, 32'(sample_en), 32'd0);
        check({tag, " hold"}, 32'(sample), 32'(got));
        next_cyc += CLK_DIV;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset sample", 32'(sample), 32'd0);
        check("reset sample_en", 32'(sample_en), 32'd0);
        next_cyc = cyc + CLK_DIV - 1 + 8;
        rst = 1'b0;

        push_expected();
        wait_strobe("t1_idle");

        ay_a = 8'd255;
        push_expected();
        wait_strobe("t2_ay_a_max");

        ay_a = 8'd255; ay_b = 8'd255; ay_c = 8'd255; covox = 8'd255; beeper = 1'b1; ear = 1'b1;
        push_expected();
        wait_strobe("t3_sat_pos");

        ay_a = 8'd0; ay_b = 8'd0; ay_c = 8'd0; covox = 8'd0; beeper = 1'b0; ear = 1'b0;
        push_expected();
        wait_strobe("t3_sat_neg");

        ay_a = 8'd255; ay_b = 8'd255; ay_c = 8'd255; covox = 8'd255; beeper = 1'b1; ear = 1'b1;
        mute = 1'b1;
        push_expected();
        wait_strobe("t4_mute");

        mute = 1'b0;
        goto_cyc(next_cyc - 8);
        mute = 1'b1;
        push_expected();
        goto_cyc(next_cyc - 7);
        mute = 1'b0;
        wait_strobe("t4_mute_at_snap");

        mute = 1'b1;
        goto_cyc(next_cyc - 8);
        mute = 1'b0;
        push_expected();
        goto_cyc(next_cyc - 7);
        mute = 1'b1;
        wait_strobe("t4_unmute_at_snap");
        mute = 1'b0;

        ay_a = 8'd255; ay_b = 8'd128; ay_c = 8'd128; covox = 8'd128; beeper = 1'b0; ear = 1'b0;
        push_expected();
        goto_cyc(next_cyc - 7);
        ay_a = 8'd0;
        goto_cyc(next_cyc - 5);
        vol = 16'h0000;
        goto_cyc(next_cyc - 3);
        ay_a = 8'd200;
        wait_strobe("t4_toggle_acc");

        ay_a = 8'd128; vol = 16'h0000; beeper = 1'b1; ear = 1'b0;
        push_expected();
        goto_cyc(next_cyc - 7);
        beeper = 1'b0;
        wait_strobe("t5_beeper_flip");

        vol = 16'hFFFF; beeper = 1'b0; ear = 1'b0;
        goto_cyc(next_cyc - 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6 reset sample", 32'(sample), 32'd0);
        check("t6 reset sample_en", 32'(sample_en), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t6 no strobe in reset", 32'(sample_en), 32'd0);
        end
        next_cyc = cyc + CLK_DIV - 1 + 8;
        rst = 1'b0;
        push_expected();
        wait_strobe("t6_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
